fsk_period_demod: RTL and testbench

Parametrised period-measuring FSK demodulator for the ultrasonic receive path. It sits between the comparator-squared receive input and the bit/frame recovery logic. It synchronises and deglitches the raw FSK square wave and measures edge-to-edge intervals over a configurable window. Each window is sliced against a threshold with hysteresis. Per window it emits a bit, a validity strobe, the raw measurement and a carrier-present flag.

---
 rtl/fsk_period_demod_if.sv | 15 +
 rtl/fsk_period_demod.sv | 113 +++++++++++
 tb/tb_fsk_period_demod.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fsk_period_demod_if.sv
// fsk_period_demod_if: control and result bundle for the FSK period demodulator
//   master: drives en and fsk_in, observes the demodulated results
//   slave : the demodulator side
interface fsk_period_demod_if #(
  parameter int SUM_W = 18
);
  logic en;
  logic fsk_in;
  logic data_out;
  logic data_valid;
  logic carrier_ok;
  logic [SUM_W-1:0] sum_out;
  modport master(output en, fsk_in, input data_out, data_valid, carrier_ok, sum_out);
  modport slave(input en, fsk_in, output data_out, data_valid, carrier_ok, sum_out);
endinterface

// File: rtl/fsk_period_demod.sv
// fsk_period_demod: period-measuring FSK demodulator with deglitching and hysteresis slicing
//   clk              system clock
//   rst              asynchronous active-high reset
//   bus.en           enable; low returns the block to IDLE (conditioning keeps running)
//   bus.fsk_in       raw asynchronous FSK square wave
//   bus.data_out     demodulated bit, held between decisions
//   bus.data_valid   one-cycle pulse when data_out/sum_out update
//   bus.carrier_ok   high while a carrier is being tracked
//   bus.sum_out      interval sum of the last completed window
module fsk_period_demod #(
  parameter int CNT_W              = 14,
  parameter int COUNTER_MAX        = 10000,
  parameter int PERIODS_TO_MEASURE = 2,
  parameter int SUM_W              = 18,
  parameter int THRESHOLD          = 160,
  parameter int HYST               = 8,
  parameter int GLITCH_CYCLES      = 3,
  parameter int EDGE_MODE          = 0
) (
  input logic clk,
  input logic rst,
  fsk_period_demod_if.slave bus
);
  localparam logic [SUM_W-1:0] HI = SUM_W'(THRESHOLD + HYST);
  localparam logic [SUM_W-1:0] LO = SUM_W'(THRESHOLD - HYST);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t r_state;
  logic [1:0] r_sync;
  logic r_filt, r_filt_d;
  logic [3:0] r_gcnt;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_sum, r_sum_out;
  logic [3:0] r_n;
  logic r_data, r_valid, r_carrier;
  logic w_strobe, w_sat, w_last;
  logic [SUM_W-1:0] w_total;
  // Strobe is taken from the registered filter output so every edge sees the same pipeline delay.
  assign w_strobe = (EDGE_MODE != 0) ? (r_filt & ~r_filt_d) : (r_filt ^ r_filt_d);
  assign w_sat    = r_cnt == CNT_W'(COUNTER_MAX);
  assign w_last   = r_n == 4'(PERIODS_TO_MEASURE - 1);
  // r_cnt already equals the distance to the previous strobe when the strobe arrives.
  assign w_total  = r_sum + SUM_W'(r_cnt);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_gcnt   <= '0;
    end else begin
      r_sync   <= {r_sync[0], bus.fsk_in};
      r_filt_d <= r_filt;
      // Accept a new level only after GLITCH_CYCLES consecutive differing samples.
      if (r_sync[1] == r_filt) r_gcnt <= '0;
      else if (r_gcnt == 4'(GLITCH_CYCLES - 1)) begin
        r_filt <= r_sync[1];
        r_gcnt <= '0;
      end else r_gcnt <= r_gcnt + 4'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (!bus.en) r_cnt <= '0;
    else if (w_strobe) r_cnt <= CNT_W'(1);
    else if (!w_sat) r_cnt <= r_cnt + CNT_W'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sum     <= '0;
      r_n       <= '0;
      r_data    <= 1'b0;
      r_valid   <= 1'b0;
      r_carrier <= 1'b0;
      r_sum_out <= '0;
    end else begin
      r_valid <= 1'b0;
      if (!bus.en) begin
        r_state   <= IDLE;
        r_sum     <= '0;
        r_n       <= '0;
        r_carrier <= 1'b0;
      end else if (r_state == IDLE) begin
        if (w_strobe) begin
          r_state <= MEASURE;
          r_sum   <= '0;
          r_n     <= '0;
        end
      end else if (w_strobe) begin
        // A strobe coinciding with saturation is still accumulated with D=COUNTER_MAX.
        if (w_last) begin
          r_sum     <= '0;
          r_n       <= '0;
          r_valid   <= 1'b1;
          r_sum_out <= w_total;
          r_carrier <= 1'b1;
          r_data    <= (w_total > HI) ? 1'b0 : (w_total < LO) ? 1'b1 : r_data;
        end else begin
          r_sum <= w_total;
          r_n   <= r_n + 4'(1);
        end
      end else if (w_sat) begin
        r_state   <= IDLE;
        r_sum     <= '0;
        r_n       <= '0;
        r_carrier <= 1'b0;
      end
    end
  end
  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.carrier_ok = r_carrier;
  assign bus.sum_out    = r_sum_out;
endmodule

// File: tb/tb_fsk_period_demod.sv
// tb_fsk_period_demod: scoreboard bench for the FSK period demodulator
module tb_fsk_period_demod;
  localparam int SUM_W = 18, CMAX = 10000, N = 2, TH = 160, HY = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fsk_period_demod_if #(.SUM_W(SUM_W)) bus();
  fsk_period_demod dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int q_sum[$];
  bit q_do[$];
  bit m_idle = 1'b1, m_do = 1'b0;
  int m_sum = 0, m_n = 0, m_last_edge = 0, m_last_sum = 0;
  bit prev_v = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // Reference model at the edge level: each accepted raw edge becomes one strobe with fixed latency.
  task automatic edge_now();
    int gap, s;
    gap = cyc - m_last_edge;
    m_last_edge = cyc;
    bus.fsk_in = ~bus.fsk_in;
    if (m_idle || gap > CMAX) begin
      m_idle = 1'b0;
      m_sum = 0;
      m_n = 0;
    end else begin
      s = m_sum + gap;
      if (m_n == N - 1) begin
        m_do = (s > TH + HY) ? 1'b0 : (s < TH - HY) ? 1'b1 : m_do;
        m_last_sum = s;
        q_sum.push_back(s);
        q_do.push_back(m_do);
        m_sum = 0;
        m_n = 0;
      end else begin
        m_sum = s;
        m_n++;
      end
    end
  endtask
  task automatic half(input int len);
    @(negedge clk) edge_now();
    repeat (len - 1) @(negedge clk);
  endtask
  task automatic half_glitch(input int len);
    @(negedge clk) edge_now();
    repeat (19) @(negedge clk);
    bus.fsk_in = ~bus.fsk_in;
    repeat (2) @(negedge clk);
    bus.fsk_in = ~bus.fsk_in;
    repeat (len - 22) @(negedge clk);
  endtask
  task automatic half_pulse(input int len);
    @(negedge clk) edge_now();
    repeat (19) @(negedge clk);
    edge_now();
    repeat (3) @(negedge clk);
    edge_now();
    repeat (len - 23) @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, bus.data_out, 0);
    check({tag, "_valid"}, bus.data_valid, 0);
    check({tag, "_carrier"}, bus.carrier_ok, 0);
    check({tag, "_sum_out"}, bus.sum_out, 0);
  endtask
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.data_valid === 1'b1) begin
      if (prev_v) check("valid_back_to_back", 1, 0);
      if (q_sum.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        check("sum_out", bus.sum_out, q_sum.pop_front());
        check("data_out", bus.data_out, q_do.pop_front());
        check("carrier_on_valid", bus.carrier_ok, 1);
      end
    end
    prev_v <= (bus.data_valid === 1'b1);
  end
  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.fsk_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    bus.en = 1'b1;
    m_last_edge = cyc;
    repeat (5) @(negedge clk);
    repeat (9) half(50);
    check("carrier_locked", bus.carrier_ok, 1);
    check("short_period_bit", bus.data_out, 1);
    repeat (8) half(100);
    check("long_period_bit", bus.data_out, 0);
    repeat (8) half(81);
    check("hyst_hold", bus.data_out, 0);
    repeat (8) half(70);
    check("below_band_bit", bus.data_out, 1);
    repeat (6) half_glitch(50);
    half_pulse(50);
    repeat (4) half(50);
    @(negedge clk) edge_now();
    repeat (10005) @(posedge clk);
    @(negedge clk);
    check("carrier_before_sat", bus.carrier_ok, 1);
    @(negedge clk);
    check("carrier_after_sat", bus.carrier_ok, 0);
    check("hold_after_sat", bus.sum_out, m_last_sum);
    half(50);
    check("carrier_idle_first_edge", bus.carrier_ok, 0);
    repeat (5) half(50);
    check("carrier_relock", bus.carrier_ok, 1);
    if (bus.fsk_in) half(50);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    m_idle = 1'b1;
    m_do = 1'b0;
    m_last_sum = 0;
    repeat (5) @(negedge clk);
    repeat (7) half(50);
    bus.en = 1'b0;
    repeat (10) @(negedge clk);
    check("en_low_carrier", bus.carrier_ok, 0);
    check("en_low_valid", bus.data_valid, 0);
    check("en_low_data_hold", bus.data_out, m_do);
    check("en_low_sum_hold", bus.sum_out, m_last_sum);
    bus.en = 1'b1;
    m_idle = 1'b1;
    repeat (7) half(100);
    repeat (20) @(negedge clk);
    check("scoreboard_empty", q_sum.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
